result_collector: RTL and testbench

Downstream stage of `computing_cascade`. It captures per-channel phase (`ph`) and amplitude (`ac`) results as they leave the cascade and assembles them into complete sweeps, one result per channel. It streams each finished sweep to the host/readout logic over a valid/ready handshake. Double banking lets the cascade keep producing results while the previous sweep drains.

---
 rtl/result_collector.sv | 146 ++++++++++++++
 tb/tb_result_collector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Collects per-channel cascade results into double-banked sweeps and streams each sweep in channel order.
// Latency: first beat one cycle after the completing write; o_rdy stalls hold the beat; a sweep completing while the previous one is still draining is dropped with ovf.
module result_collector #(
    parameter int CHANELS     = 4,
    parameter int PH_WIDTH    = 32,
    parameter int AC_WIDTH    = 32,
    parameter int SWEEP_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_vld,
    input  logic [$clog2(CHANELS)-1:0]  i_addr,
    input  logic signed [PH_WIDTH-1:0]  i_ph,
    input  logic [AC_WIDTH-1:0]         i_ac,
    output logic                        o_vld,
    input  logic                        o_rdy,
    output logic [$clog2(CHANELS)-1:0]  o_chan,
    output logic signed [PH_WIDTH-1:0]  o_ph,
    output logic [AC_WIDTH-1:0]         o_ac,
    output logic [SWEEP_WIDTH-1:0]      o_sweep,
    output logic                        o_last,
    output logic                        ovf,
    output logic                        dup_err
);

    localparam int AW = $clog2(CHANELS);
    localparam logic [AW-1:0] LAST_IDX = AW'(CHANELS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_q, state_d;
    logic                       bank_q, bank_d;
    logic [CHANELS-1:0]         fresh_q, fresh_d;
    logic [SWEEP_WIDTH-1:0]     sweep_cnt_q, sweep_cnt_d;
    logic [AW-1:0]              o_chan_q, o_chan_d;
    logic signed [PH_WIDTH-1:0] o_ph_q, o_ph_d;
    logic [AC_WIDTH-1:0]        o_ac_q, o_ac_d;
    logic [SWEEP_WIDTH-1:0]     o_sweep_q, o_sweep_d;
    logic                       o_last_q, o_last_d;
    logic                       ovf_q, ovf_d;
    logic                       dup_q, dup_d;
    logic signed [PH_WIDTH-1:0] ph_mem_q [2][CHANELS];
    logic signed [PH_WIDTH-1:0] ph_mem_d [2][CHANELS];
    logic [AC_WIDTH-1:0]        ac_mem_q [2][CHANELS];
    logic [AC_WIDTH-1:0]        ac_mem_d [2][CHANELS];

    logic               wr_en;
    logic               complete;
    logic               last_hs;
    logic               swap_ok;
    logic [CHANELS-1:0] fresh_set;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        sweep_cnt_d = sweep_cnt_q;
        o_chan_d    = o_chan_q;
        o_ph_d      = o_ph_q;
        o_ac_d      = o_ac_q;
        o_sweep_d   = o_sweep_q;
        o_last_d    = o_last_q;
        ph_mem_d    = ph_mem_q;
        ac_mem_d    = ac_mem_q;
        fresh_set   = fresh_q;

        wr_en = i_vld && (int'(i_addr) < CHANELS);
        if (wr_en) begin
            fresh_set[i_addr]        = 1'b1;
            ph_mem_d[bank_q][i_addr] = i_ph;
            ac_mem_d[bank_q][i_addr] = i_ac;
        end
        complete = wr_en && (&fresh_set);
        last_hs  = (state_q == SEND) && o_rdy && (o_chan_q == LAST_IDX);
        swap_ok  = (state_q == IDLE) || last_hs;

        ovf_d   = complete && !swap_ok;
        dup_d   = wr_en && fresh_q[i_addr];
        fresh_d = complete ? '0 : fresh_set;
        if (complete) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
        end

        if (complete && swap_ok) begin
            // Read from the _d view so a completing write to channel 0 is seen by beat 0.
            bank_d    = ~bank_q;
            state_d   = SEND;
            o_chan_d  = '0;
            o_ph_d    = ph_mem_d[bank_q][0];
            o_ac_d    = ac_mem_d[bank_q][0];
            o_sweep_d = sweep_cnt_q;
            o_last_d  = (CHANELS == 1);
        end else if ((state_q == SEND) && o_rdy) begin
            if (o_chan_q == LAST_IDX) begin
                state_d  = IDLE;
                o_last_d = 1'b0;
            end else begin
                o_chan_d = o_chan_q + 1'b1;
                o_ph_d   = ph_mem_q[~bank_q][o_chan_d];
                o_ac_d   = ac_mem_q[~bank_q][o_chan_d];
                o_last_d = (o_chan_d == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            fresh_q     <= '0;
            sweep_cnt_q <= '0;
            o_chan_q    <= '0;
            o_ph_q      <= '0;
            o_ac_q      <= '0;
            o_sweep_q   <= '0;
            o_last_q    <= 1'b0;
            ovf_q       <= 1'b0;
            dup_q       <= 1'b0;
            ph_mem_q    <= '{default: '0};
            ac_mem_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            fresh_q     <= fresh_d;
            sweep_cnt_q <= sweep_cnt_d;
            o_chan_q    <= o_chan_d;
            o_ph_q      <= o_ph_d;
            o_ac_q      <= o_ac_d;
            o_sweep_q   <= o_sweep_d;
            o_last_q    <= o_last_d;
            ovf_q       <= ovf_d;
            dup_q       <= dup_d;
            ph_mem_q    <= ph_mem_d;
            ac_mem_q    <= ac_mem_d;
        end
    end

    assign o_vld   = (state_q == SEND);
    assign o_chan  = o_chan_q;
    assign o_ph    = o_ph_q;
    assign o_ac    = o_ac_q;
    assign o_sweep = o_sweep_q;
    assign o_last  = o_last_q;
    assign ovf     = ovf_q;
    assign dup_err = dup_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed and randomized bench for result_collector against a queue-of-beats reference model.
module tb_result_collector;

    localparam int C  = 4;
    localparam int SW = 4;

    logic        clk;
    logic        rstn;
    logic        i_vld;
    logic [1:0]  i_addr;
    logic [31:0] i_ph;
    logic [31:0] i_ac;
    logic        o_vld;
    logic        o_rdy;
    logic [1:0]  o_chan;
    logic [31:0] o_ph;
    logic [31:0] o_ac;
    logic [SW-1:0] o_sweep;
    logic        o_last;
    logic        ovf;
    logic        dup_err;

    result_collector #(
        .CHANELS(C), .PH_WIDTH(32), .AC_WIDTH(32), .SWEEP_WIDTH(SW)
    ) dut (
        .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_addr(i_addr), .i_ph(i_ph), .i_ac(i_ac),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_chan(o_chan), .o_ph(o_ph), .o_ac(o_ac),
        .o_sweep(o_sweep), .o_last(o_last), .ovf(ovf), .dup_err(dup_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]    chan;
        logic [31:0]   ph;
        logic [31:0]   ac;
        logic [SW-1:0] sweep;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] m_ph[C];
    logic [31:0] m_ac[C];
    bit          m_fresh[C];
    int          m_cnt;
    bit          exp_ovf;
    bit          exp_dup;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int c = 0; c < C; c++) m_fresh[c] = 1'b0;
        m_cnt   = 0;
        exp_ovf = 1'b0;
        exp_dup = 1'b0;
    endtask

    // Checks the outputs visible this cycle, advances the model over the next edge, then clocks.
    task automatic cycle(input bit vld, input int addr, input logic [31:0] ph,
                         input logic [31:0] ac, input bit rdy);
        bit   all_fresh;
        beat_t b;
        chk("o_vld", 64'(o_vld), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("o_chan", 64'(o_chan), 64'(exp_q[0].chan));
            chk("o_ph", 64'(o_ph), 64'(exp_q[0].ph));
            chk("o_ac", 64'(o_ac), 64'(exp_q[0].ac));
            chk("o_sweep", 64'(o_sweep), 64'(exp_q[0].sweep));
            chk("o_last", 64'(o_last), 64'(exp_q[0].chan == 2'(C - 1)));
        end
        chk("ovf", 64'(ovf), 64'(exp_ovf));
        chk("dup_err", 64'(dup_err), 64'(exp_dup));

        exp_ovf = 1'b0;
        exp_dup = 1'b0;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (vld) begin
            if (m_fresh[addr]) exp_dup = 1'b1;
            m_ph[addr]    = ph;
            m_ac[addr]    = ac;
            m_fresh[addr] = 1'b1;
            all_fresh = 1'b1;
            for (int c = 0; c < C; c++) if (!m_fresh[c]) all_fresh = 1'b0;
            if (all_fresh) begin
                if (exp_q.size() == 0) begin
                    for (int c = 0; c < C; c++) begin
                        b.chan  = 2'(c);
                        b.ph    = m_ph[c];
                        b.ac    = m_ac[c];
                        b.sweep = SW'(m_cnt);
                        exp_q.push_back(b);
                    end
                end else begin
                    exp_ovf = 1'b1;
                end
                m_cnt = (m_cnt + 1) % (1 << SW);
                for (int c = 0; c < C; c++) m_fresh[c] = 1'b0;
            end
        end

        i_vld  = vld;
        i_addr = 2'(addr);
        i_ph   = ph;
        i_ac   = ac;
        o_rdy  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_vld = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("rst_o_vld", 64'(o_vld), 64'd0);
        chk("rst_o_chan", 64'(o_chan), 64'd0);
        chk("rst_o_ph", 64'(o_ph), 64'd0);
        chk("rst_o_ac", 64'(o_ac), 64'd0);
        chk("rst_o_sweep", 64'(o_sweep), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dup_err", 64'(dup_err), 64'd0);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rstn   = 1'b1;
        i_vld  = 1'b0;
        i_addr = '0;
        i_ph   = '0;
        i_ac   = '0;
        o_rdy  = 1'b0;
        model_clear();
        #2;
        do_reset();

        // In-order sweep
        for (int c = 0; c < C; c++) cycle(1'b1, c, 32'(10 * (c + 1)), 32'(c + 1), 1'b1);
        idle(6, 1'b1);

        // Out-of-order arrival with a negative phase
        do_reset();
        cycle(1'b1, 2, -32'sd5, 32'd33, 1'b1);
        cycle(1'b1, 0, 32'd100, 32'd11, 1'b1);
        cycle(1'b1, 3, 32'd300, 32'd44, 1'b1);
        cycle(1'b1, 1, 32'd200, 32'd22, 1'b1);
        idle(6, 1'b1);

        // Backpressure on beat ch 1
        for (int c = 0; c < C; c++) cycle(1'b1, c, 32'(c + 50), 32'(c + 60), 1'b1);
        idle(1, 1'b1);
        idle(5, 1'b0);
        idle(5, 1'b1);

        // Overflow: two full sweeps while the consumer stalls
        do_reset();
        for (int c = 0; c < 2 * C; c++) cycle(1'b1, c % C, 32'(c + 1000), 32'(c + 2000), 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);
        for (int c = 0; c < C; c++) cycle(1'b1, c, 32'(c + 3000), 32'(c + 4000), 1'b1);
        idle(6, 1'b1);

        // Duplicate write to ch 1
        cycle(1'b1, 1, 32'd7, 32'd70, 1'b1);
        cycle(1'b1, 0, 32'd5, 32'd50, 1'b1);
        cycle(1'b1, 1, 32'd9, 32'd90, 1'b1);
        cycle(1'b1, 2, 32'd6, 32'd60, 1'b1);
        cycle(1'b1, 3, 32'd8, 32'd80, 1'b1);
        idle(6, 1'b1);

        // Back-to-back: second sweep completes on the last-beat handshake
        do_reset();
        for (int c = 0; c < 2 * C; c++) cycle(1'b1, c % C, 32'(c * 3), 32'(c * 5), 1'b1);
        idle(6, 1'b1);

        // Reset in the middle of a sweep, then a fresh sweep numbered 0
        for (int c = 0; c < C; c++) cycle(1'b1, c, 32'(c + 77), 32'(c + 88), 1'b1);
        idle(2, 1'b1);
        do_reset();
        for (int c = 0; c < C; c++) cycle(1'b1, C - 1 - c, $urandom, $urandom, 1'b1);
        idle(6, 1'b1);

        // Randomized traffic, long enough for the sweep counter to wrap
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 99) < 60, int'($urandom_range(0, C - 1)),
                  $urandom, $urandom, $urandom_range(0, 99) < 70);
        end
        idle(10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
